// File: rtl/disp_scan_arbiter.sv
// disp_scan_arbiter: two-port round-robin write arbiter into an 8x4-bit digit
// buffer, plus a prescaled scan scheduler driving the anodes of an 8-digit
// common-anode 7-segment display and the nibble for the segment decoder.
module disp_scan_arbiter #(
    parameter int DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [2:0] addr0,
    input  logic [3:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [2:0] addr1,
    input  logic [3:0] data1,
    output logic       ack1,
    input  logic [7:0] en,
    output logic [7:0] an,
    output logic [3:0] hex,
    output logic       frame
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [3:0]    digit_buf [8];
    logic          last;
    logic [PW-1:0] p;
    logic [2:0]    d;
    logic          elig0, elig1;
    logic          gnt0, gnt1;
    logic          p_wrap;

    // Eligibility and round-robin grant: a requester is blocked while its own
    // ack is high, and ties go to whoever did not win most recently.
    always_comb begin
        elig0 = req0 & ~ack0;
        elig1 = req1 & ~ack1;
        gnt0  = elig0 & (~elig1 | last);
        gnt1  = elig1 & (~elig0 | ~last);
    end

    // Write port: at most one buffer write per edge, ack pulses one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            last <= 1'b1;
            for (int i = 0; i < 8; i++) begin
                digit_buf[i] <= 4'h0;
            end
        end else begin
            ack0 <= gnt0;
            ack1 <= gnt1;
            if (gnt0) begin
                digit_buf[addr0] <= data0;
                last             <= 1'b0;
            end else if (gnt1) begin
                digit_buf[addr1] <= data1;
                last             <= 1'b1;
            end
        end
    end

    // Prescaler end-of-slot decode.
    always_comb begin
        p_wrap = (p == PMAX);
    end

    // Scan scheduler: prescaler counts DIV cycles per digit slot, then the
    // digit counter advances; independent of write traffic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            p <= '0;
            d <= 3'd0;
        end else if (p_wrap) begin
            p <= '0;
            d <= d + 3'd1;
        end else begin
            p <= p + PW'(1);
        end
    end

    // Display outputs: masked digits keep their slot but leave anodes off;
    // frame marks the last cycle before the scan wraps back to digit 0.
    always_comb begin
        an    = en[d] ? ~(8'h01 << d) : 8'hFF;
        hex   = digit_buf[d];
        frame = p_wrap & (d == 3'd7);
    end

endmodule

// File: tb/tb_disp_scan_arbiter.sv
// Directed self-checking bench for disp_scan_arbiter with DIV=4.
module tb_disp_scan_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [2:0] addr0, addr1;
    logic [3:0] data0, data1;
    logic       ack0, ack1;
    logic [7:0] en;
    logic [7:0] an;
    logic [3:0] hex;
    logic       frame;

    int n_assert = 0;
    int n_fail   = 0;
    int k        = 0;   // cycles since last reset edge (0 = first cycle after it)

    disp_scan_arbiter #(.DIV(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
        .en(en), .an(an), .hex(hex), .frame(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        if (rst == 1'b0) k = 0;
        else k++;
        #1;
    endtask

    function automatic logic [7:0] onehot_an(input int s);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << s);
    endfunction

    task automatic wait_slot(input int s);
        int n;
        n = 0;
        while ((((k % 32) / 4) != s || (k % 4) != 0) && n < 40) begin
            step();
            n++;
        end
        chk("wait_slot", 32'(n < 40), 32'd1);
    endtask

    initial begin
        int frames;
        int s;
        rst = 1'b0; en = 8'hFF;
        req0 = 1'b0; addr0 = 3'd0; data0 = 4'h0;
        req1 = 1'b0; addr1 = 3'd0; data1 = 4'h0;

        // Reset held for 2 cycles
        step(); step();
        chk("rst_an", 32'(an), 32'hFE);
        chk("rst_hex", 32'(hex), 32'h0);
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_ack1", 32'(ack1), 32'd0);
        chk("rst_frame", 32'(frame), 32'd0);
        rst = 1'b1;

        // Free-running scan over two frames
        frames = 0;
        for (int i = 1; i <= 64; i++) begin
            step();
            s = (k % 32) / 4;
            chk("scan_an", 32'(an), 32'(onehot_an(s)));
            chk("scan_frame", 32'(frame), 32'((k % 32) == 31));
            if (frame) frames++;
        end
        chk("scan_frame_count", 32'(frames), 32'd2);

        // Single write to digit 3
        req0 = 1'b1; addr0 = 3'd3; data0 = 4'hA;
        step();
        chk("wr_ack0_hi", 32'(ack0), 32'd1);
        step();
        chk("wr_ack0_lo", 32'(ack0), 32'd0);
        req0 = 1'b0;
        step();
        chk("wr_ack0_stays_lo", 32'(ack0), 32'd0);
        wait_slot(3);
        chk("wr_slot3_an", 32'(an), 32'hF7);
        chk("wr_slot3_hex", 32'(hex), 32'hA);

        // Contention from reset
        rst = 1'b0;
        req0 = 1'b1; addr0 = 3'd0; data0 = 4'h1;
        req1 = 1'b1; addr1 = 3'd1; data1 = 4'h2;
        step();
        chk("cont_rst_ack0", 32'(ack0), 32'd0);
        chk("cont_rst_ack1", 32'(ack1), 32'd0);
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("cont_ack0", 32'(ack0), 32'(i % 2));
            chk("cont_ack1", 32'(ack1), 32'((i + 1) % 2));
            chk("cont_not_both", 32'(ack0 & ack1), 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_slot(0);
        chk("cont_buf0", 32'(hex), 32'h1);
        wait_slot(1);
        chk("cont_buf1", 32'(hex), 32'h2);
        wait_slot(3);
        chk("cont_buf3_cleared", 32'(hex), 32'h0);

        // Mask: upper four digits only
        en = 8'hF0;
        wait_slot(0);
        frames = 0;
        for (int i = 0; i < 32; i++) begin
            s = (k % 32) / 4;
            chk("mask_an", 32'(an), (s < 4) ? 32'hFF : 32'(onehot_an(s)));
            chk("mask_frame", 32'(frame), 32'((k % 32) == 31));
            if (frame) frames++;
            step();
        end
        chk("mask_frame_count", 32'(frames), 32'd1);
        en = 8'hFF;

        // Reset mid-write
        req1 = 1'b1; addr1 = 3'd5; data1 = 4'h7;
        step();
        chk("rmw_ack1_first", 32'(ack1), 32'd1);
        req1 = 1'b0;
        step();
        wait_slot(5);
        chk("rmw_buf5_written", 32'(hex), 32'h7);
        req1 = 1'b1; addr1 = 3'd2; data1 = 4'h9;
        rst = 1'b0;
        step();
        chk("rmw_ack1_dropped", 32'(ack1), 32'd0);
        chk("rmw_an_digit0", 32'(an), 32'hFE);
        chk("rmw_hex0", 32'(hex), 32'h0);
        rst = 1'b1;
        req1 = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            chk("rmw_hex_cleared", 32'(hex), 32'h0);
            chk("rmw_no_ack1", 32'(ack1), 32'd0);
            chk("rmw_scan_an", 32'(an), 32'(onehot_an((k % 32) / 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
